axis_arb_rr: RTL and testbench

AXIS_ARB_RR -- requirements
Module: axis_arb_rr

---
 rtl/axis_arb_rr_pkg.sv | 14 +
 rtl/axis_arb_rr_rr_select.sv | 27 ++
 rtl/axis_arb_rr.sv | 133 +++++++++++++
 tb/tb_axis_arb_rr.sv | 507 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_arb_rr_pkg.sv
// Shared types and helpers for the round-robin AXI-stream arbiter.
package axis_arb_rr_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    // Bits needed to hold a port index 0..n-1, never less than one.
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/axis_arb_rr_rr_select.sv
// Circular priority search: first set request strictly after ptr, wrapping.
module rr_select
    import axis_arb_rr_pkg::*;
#(
    parameter int  N = 6,
    localparam int W = sel_width(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] gnt_idx,
    output logic         any
);

    always_comb begin
        gnt_idx = '0;
        any     = 1'b0;
        for (int i = 1; i <= N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (!any && req[j] && (j == ((int'(ptr) + i) % N))) begin
                    gnt_idx = W'(j);
                    any     = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/axis_arb_rr.sv
// Packet-locked round-robin merge of NUM_PORTS AXI-stream slaves into one
// registered master; one arbitration cycle separates consecutive packets.
module axis_arb_rr
    import axis_arb_rr_pkg::*;
#(
    parameter int  NUM_PORTS  = 6,
    parameter int  DATA_WIDTH = 256,
    localparam int SEL_W      = sel_width(NUM_PORTS)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_PORTS-1:0]            en_mask,
    input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
    output logic [NUM_PORTS-1:0]            s_axis_tready,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_PORTS-1:0]            s_axis_tlast,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic [DATA_WIDTH-1:0]           m_axis_tdata,
    output logic                            m_axis_tlast,
    output logic [SEL_W-1:0]                m_axis_tsel
);

    localparam logic [SEL_W-1:0] PTR_RESET = SEL_W'(NUM_PORTS - 1);

    arb_state_e             state_q, state_d;
    logic [SEL_W-1:0]       grant_q, grant_d;
    logic [SEL_W-1:0]       ptr_q, ptr_d;
    logic                   m_valid_q, m_valid_d;
    logic [DATA_WIDTH-1:0]  m_data_q, m_data_d;
    logic                   m_last_q, m_last_d;
    logic [SEL_W-1:0]       m_sel_q, m_sel_d;

    logic [NUM_PORTS-1:0]   req;
    logic [SEL_W-1:0]       rr_idx;
    logic                   rr_any;
    logic                   beat_ready;
    logic                   beat_valid;
    logic                   beat_last;
    logic [DATA_WIDTH-1:0]  beat_data;

    assign req = s_axis_tvalid & en_mask;

    rr_select #(
        .N(NUM_PORTS)
    ) u_rr_select (
        .req     (req),
        .ptr     (ptr_q),
        .gnt_idx (rr_idx),
        .any     (rr_any)
    );

    assign beat_ready = (state_q == BUSY) && (!m_valid_q || m_axis_tready);

    always_comb begin
        beat_valid    = 1'b0;
        beat_last     = 1'b0;
        beat_data     = '0;
        s_axis_tready = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (grant_q == SEL_W'(p)) begin
                beat_valid       = s_axis_tvalid[p];
                beat_last        = s_axis_tlast[p];
                beat_data        = s_axis_tdata[p*DATA_WIDTH +: DATA_WIDTH];
                s_axis_tready[p] = beat_ready;
            end
        end
    end

    // The mask and the granted port's tvalid only matter at arbitration;
    // once BUSY the grant holds until a tlast beat is taken.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_last_d  = m_last_q;
        m_sel_d   = m_sel_q;

        if (m_axis_tready) begin
            m_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (rr_any) begin
                    grant_d = rr_idx;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (beat_ready && beat_valid) begin
                    m_valid_d = 1'b1;
                    m_data_d  = beat_data;
                    m_last_d  = beat_last;
                    m_sel_d   = grant_q;
                    if (beat_last) begin
                        ptr_d   = grant_q;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            ptr_q     <= PTR_RESET;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
            m_sel_q   <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            ptr_q     <= ptr_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_last_q  <= m_last_d;
            m_sel_q   <= m_sel_d;
        end
    end

    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tdata  = m_data_q;
    assign m_axis_tlast  = m_last_q;
    assign m_axis_tsel   = m_sel_q;

endmodule

// File: tb/tb_axis_arb_rr.sv
// Self-checking bench for axis_arb_rr: packet-level round-robin reference model.
module tb_axis_arb_rr;

    localparam int NP = 4;
    localparam int DW = 32;
    localparam int SW = 2;

    typedef struct {
        logic [DW-1:0] data;
        bit            last;
    } beat_t;

    typedef struct {
        logic [DW-1:0] data;
        bit            last;
        int            sel;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NP-1:0]    en_mask;
    logic [NP-1:0]    s_axis_tvalid;
    logic [NP-1:0]    s_axis_tready;
    logic [NP*DW-1:0] s_axis_tdata;
    logic [NP-1:0]    s_axis_tlast;
    logic             m_axis_tvalid;
    logic             m_axis_tready;
    logic [DW-1:0]    m_axis_tdata;
    logic             m_axis_tlast;
    logic [SW-1:0]    m_axis_tsel;

    axis_arb_rr #(
        .NUM_PORTS  (NP),
        .DATA_WIDTH (DW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en_mask       (en_mask),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tsel   (m_axis_tsel)
    );

    always #5 clk = ~clk;

    // Source queues feed the DUT; model queues hold the same packets for prediction.
    beat_t         src_q [NP][$];
    beat_t         mdl_q [NP][$];
    exp_t          exp_q [$];
    int            hold [NP];
    logic [NP-1:0] model_mask;
    int            model_last;
    int            ready_mode;
    int            cycle;
    int            errors = 0;
    int            checks = 0;

    task automatic drive();
        for (int p = 0; p < NP; p++) begin
            if (src_q[p].size() > 0 && hold[p] == 0) begin
                s_axis_tvalid[p]           = 1'b1;
                s_axis_tdata[p*DW +: DW]   = src_q[p][0].data;
                s_axis_tlast[p]            = src_q[p][0].last;
            end else begin
                s_axis_tvalid[p]           = 1'b0;
                s_axis_tdata[p*DW +: DW]   = '0;
                s_axis_tlast[p]            = 1'b0;
            end
        end
        case (ready_mode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = ~m_axis_tready;
            default: m_axis_tready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic step(output bit ov, output bit of, output logic [DW-1:0] od,
                        output bit ol, output int os);
        logic [NP-1:0] fire;
        @(negedge clk);
        cycle++;
        ov   = m_axis_tvalid;
        of   = m_axis_tvalid & m_axis_tready;
        od   = m_axis_tdata;
        ol   = m_axis_tlast;
        os   = int'(m_axis_tsel);
        fire = s_axis_tvalid & s_axis_tready;
        @(posedge clk);
        #1;
        for (int p = 0; p < NP; p++) begin
            if (fire[p] && src_q[p].size() > 0) void'(src_q[p].pop_front());
            if (hold[p] > 0) hold[p]--;
        end
        drive();
    endtask

    task automatic load_pkt(input int p, input int len);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.data = {4'(p), 4'(i), 24'($urandom)};
            b.last = (i == len - 1);
            src_q[p].push_back(b);
            mdl_q[p].push_back(b);
        end
    endtask

    // Next output beat: whole packets, chosen round-robin after the last served port.
    task automatic model_next(output exp_t e, output bit ok);
        int    p;
        bit    found;
        beat_t b;
        e     = '{data: '0, last: 1'b0, sel: -1};
        ok    = 1'b0;
        found = 1'b0;
        if (exp_q.size() == 0) begin
            for (int i = 1; i <= NP && !found; i++) begin
                p = (model_last + i) % NP;
                if (model_mask[p] && mdl_q[p].size() > 0) begin
                    found      = 1'b1;
                    model_last = p;
                    do begin
                        b = mdl_q[p].pop_front();
                        exp_q.push_back('{data: b.data, last: b.last, sel: p});
                    end while (!b.last && mdl_q[p].size() > 0);
                end
            end
        end
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            ok = 1'b1;
        end
    endtask

    task automatic clear_all(input logic [NP-1:0] mask);
        for (int p = 0; p < NP; p++) begin
            src_q[p].delete();
            mdl_q[p].delete();
            hold[p] = 0;
        end
        exp_q.delete();
        model_last = NP - 1;
        model_mask = mask;
        en_mask    = mask;
        ready_mode = 0;
        drive();
    endtask

    task automatic reset_dut(input logic [NP-1:0] mask);
        rst_n = 1'b0;
        clear_all(mask);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle = 0;
    endtask

    task automatic test_reset();
        bit ov, of, ol;
        logic [DW-1:0] od;
        int os, got;
        exp_t e;
        bit ok;
        rst_n = 1'b0;
        clear_all(4'hF);
        for (int p = 0; p < NP; p++) load_pkt(p, 2);
        drive();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (s_axis_tready !== 4'h0) begin
            errors++;
            $display("[TB] FAIL reset_tready: got %b want 0000", s_axis_tready);
        end
        checks++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_valid_last: got %b/%b want 0/0", m_axis_tvalid, m_axis_tlast);
        end
        checks++;
        if (m_axis_tdata !== '0 || m_axis_tsel !== '0) begin
            errors++;
            $display("[TB] FAIL reset_data_sel: got %h/%0d want 0/0", m_axis_tdata, m_axis_tsel);
        end
        en_mask    = 4'h0;
        model_mask = 4'h0;
        rst_n      = 1'b1;
        cycle      = 0;
        for (int c = 0; c < 4; c++) begin
            step(ov, of, od, ol, os);
            checks++;
            if (ov || s_axis_tready !== 4'h0) begin
                errors++;
                $display("[TB] FAIL masked_idle: got valid=%0d tready=%b want 0 and 0000", ov, s_axis_tready);
            end
        end
        en_mask    = 4'hF;
        model_mask = 4'hF;
        drive();
        got = 0;
        for (int c = 0; c < 100 && got < 8; c++) begin
            step(ov, of, od, ol, os);
            if (of) begin
                model_next(e, ok);
                checks++;
                if (!ok || od !== e.data || ol !== e.last || os !== e.sel) begin
                    errors++;
                    $display("[TB] FAIL reset_order beat %0d: got %h/%0d/%0d want %h/%0d/%0d",
                             got, od, ol, os, e.data, e.last, e.sel);
                end
                got++;
            end
        end
        checks++;
        if (got != 8) begin
            errors++;
            $display("[TB] FAIL reset_timeout: got %0d beats want 8", got);
        end
    endtask

    task automatic test_fairness();
        bit ov, of, ol, ok, prev_last;
        logic [DW-1:0] od;
        int os, got, prev_cycle;
        exp_t e;
        reset_dut(4'hF);
        for (int p = 0; p < NP; p++) for (int k = 0; k < 3; k++) load_pkt(p, 2);
        drive();
        got = 0; prev_cycle = 0; prev_last = 1'b0;
        for (int c = 0; c < 300 && got < 24; c++) begin
            step(ov, of, od, ol, os);
            if (of) begin
                model_next(e, ok);
                checks++;
                if (!ok || od !== e.data || ol !== e.last || os !== e.sel) begin
                    errors++;
                    $display("[TB] FAIL fair_beat %0d: got %h/%0d/%0d want %h/%0d/%0d",
                             got, od, ol, os, e.data, e.last, e.sel);
                end
                checks++;
                if (got == 0) begin
                    if (cycle != 3) begin
                        errors++;
                        $display("[TB] FAIL first_latency: got cycle %0d want 3", cycle);
                    end
                end else if (cycle - prev_cycle != (prev_last ? 2 : 1)) begin
                    errors++;
                    $display("[TB] FAIL fair_gap beat %0d: got %0d want %0d",
                             got, cycle - prev_cycle, prev_last ? 2 : 1);
                end
                prev_cycle = cycle;
                prev_last  = ol;
                got++;
            end
        end
        checks++;
        if (got != 24) begin
            errors++;
            $display("[TB] FAIL fair_timeout: got %0d beats want 24", got);
        end
    endtask

    task automatic test_backpressure();
        bit ov, of, ol, ok, prev_stall, stall_seen;
        logic [DW-1:0] od, pd;
        bit pl;
        int os, ps, got;
        exp_t e;
        reset_dut(4'hF);
        ready_mode = 1;
        load_pkt(2, 4);
        drive();
        got = 0; prev_stall = 1'b0; stall_seen = 1'b0; pd = '0; pl = 1'b0; ps = 0;
        for (int c = 0; c < 100 && got < 4; c++) begin
            step(ov, of, od, ol, os);
            if (prev_stall) begin
                checks++;
                if (!ov || od !== pd || ol !== pl || os !== ps) begin
                    errors++;
                    $display("[TB] FAIL stall_hold: got %0d/%h/%0d/%0d want 1/%h/%0d/%0d",
                             ov, od, ol, os, pd, pl, ps);
                end
            end
            prev_stall = ov && !of;
            if (prev_stall) stall_seen = 1'b1;
            pd = od; pl = ol; ps = os;
            if (of) begin
                model_next(e, ok);
                checks++;
                if (!ok || od !== e.data || ol !== e.last || os !== e.sel) begin
                    errors++;
                    $display("[TB] FAIL bp_beat %0d: got %h/%0d/%0d want %h/%0d/%0d",
                             got, od, ol, os, e.data, e.last, e.sel);
                end
                got++;
            end
        end
        checks++;
        if (got != 4 || !stall_seen) begin
            errors++;
            $display("[TB] FAIL bp_done: got %0d beats stall=%0d want 4 beats stall=1", got, stall_seen);
        end
    endtask

    task automatic test_lock();
        bit ov, of, ol, ok;
        logic [DW-1:0] od;
        int os, got;
        exp_t e;
        reset_dut(4'hF);
        load_pkt(1, 5);
        drive();
        got = 0;
        for (int c = 0; c < 100 && got < 7; c++) begin
            step(ov, of, od, ol, os);
            if (of) begin
                model_next(e, ok);
                checks++;
                if (!ok || od !== e.data || ol !== e.last || os !== e.sel) begin
                    errors++;
                    $display("[TB] FAIL lock_beat %0d: got %h/%0d/%0d want %h/%0d/%0d",
                             got, od, ol, os, e.data, e.last, e.sel);
                end
                got++;
                if (got == 1) begin
                    load_pkt(0, 2);
                    hold[1] = 3;
                    drive();
                end
            end
        end
        checks++;
        if (got != 7) begin
            errors++;
            $display("[TB] FAIL lock_timeout: got %0d beats want 7", got);
        end
    endtask

    task automatic test_mask();
        bit ov, of, ol, ok, cleared;
        logic [DW-1:0] od;
        int os, got;
        exp_t e;
        reset_dut(4'b1010);
        for (int p = 0; p < NP; p++) for (int k = 0; k < 3; k++) load_pkt(p, 4);
        drive();
        got = 0; cleared = 1'b0;
        for (int c = 0; c < 200 && got < 16; c++) begin
            step(ov, of, od, ol, os);
            if (of) begin
                model_next(e, ok);
                checks++;
                if (!ok || od !== e.data || ol !== e.last || os !== e.sel) begin
                    errors++;
                    $display("[TB] FAIL mask_beat %0d: got %h/%0d/%0d want %h/%0d/%0d",
                             got, od, ol, os, e.data, e.last, e.sel);
                end
                got++;
                if (!cleared && os == 1) begin
                    cleared    = 1'b1;
                    en_mask    = 4'b1000;
                    model_mask = 4'b1000;
                end
            end
        end
        checks++;
        if (got != 16) begin
            errors++;
            $display("[TB] FAIL mask_timeout: got %0d beats want 16", got);
        end
        for (int c = 0; c < 6; c++) begin
            step(ov, of, od, ol, os);
            checks++;
            if (of) begin
                errors++;
                $display("[TB] FAIL mask_quiet: got beat sel=%0d want none", os);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ov, of, ol, ok;
        logic [DW-1:0] od;
        int os, got;
        exp_t e;
        reset_dut(4'hF);
        load_pkt(0, 5);
        drive();
        got = 0;
        for (int c = 0; c < 50 && got < 2; c++) begin
            step(ov, of, od, ol, os);
            if (of) got++;
        end
        #2;
        checks++;
        if (m_axis_tvalid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_pre_valid: got %b want 1", m_axis_tvalid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || s_axis_tready !== 4'h0) begin
            errors++;
            $display("[TB] FAIL mid_async_ctrl: got valid=%b last=%b tready=%b want 0 0 0000",
                     m_axis_tvalid, m_axis_tlast, s_axis_tready);
        end
        checks++;
        if (m_axis_tdata !== '0 || m_axis_tsel !== '0) begin
            errors++;
            $display("[TB] FAIL mid_async_data: got %h/%0d want 0/0", m_axis_tdata, m_axis_tsel);
        end
        reset_dut(4'hF);
        load_pkt(2, 3);
        drive();
        got = 0;
        for (int c = 0; c < 50 && got < 3; c++) begin
            step(ov, of, od, ol, os);
            if (of) begin
                model_next(e, ok);
                checks++;
                if (!ok || od !== e.data || ol !== e.last || os !== e.sel) begin
                    errors++;
                    $display("[TB] FAIL mid_after beat %0d: got %h/%0d/%0d want %h/%0d/%0d",
                             got, od, ol, os, e.data, e.last, e.sel);
                end
                got++;
            end
        end
        checks++;
        if (got != 3) begin
            errors++;
            $display("[TB] FAIL mid_timeout: got %0d beats want 3", got);
        end
    endtask

    task automatic test_random();
        bit ov, of, ol, ok, prev_stall;
        logic [DW-1:0] od, pd;
        bit pl;
        int os, ps, got, total, len;
        exp_t e;
        reset_dut(4'hF);
        ready_mode = 2;
        total = 0;
        for (int k = 0; k < 24; k++) begin
            len = int'($urandom_range(1, 4));
            load_pkt(int'($urandom_range(0, NP - 1)), len);
            total += len;
        end
        drive();
        got = 0; prev_stall = 1'b0; pd = '0; pl = 1'b0; ps = 0;
        for (int c = 0; c < 3000 && got < total; c++) begin
            step(ov, of, od, ol, os);
            if (prev_stall) begin
                checks++;
                if (!ov || od !== pd || ol !== pl || os !== ps) begin
                    errors++;
                    $display("[TB] FAIL rnd_stall: got %0d/%h/%0d/%0d want 1/%h/%0d/%0d",
                             ov, od, ol, os, pd, pl, ps);
                end
            end
            prev_stall = ov && !of;
            pd = od; pl = ol; ps = os;
            if (of) begin
                model_next(e, ok);
                checks++;
                if (!ok || od !== e.data || ol !== e.last || os !== e.sel) begin
                    errors++;
                    $display("[TB] FAIL rnd_beat %0d: got %h/%0d/%0d want %h/%0d/%0d",
                             got, od, ol, os, e.data, e.last, e.sel);
                end
                got++;
            end
        end
        checks++;
        if (got != total) begin
            errors++;
            $display("[TB] FAIL rnd_timeout: got %0d beats want %0d", got, total);
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        en_mask       = '0;
        s_axis_tvalid = '0;
        s_axis_tdata  = '0;
        s_axis_tlast  = '0;
        m_axis_tready = 1'b1;
        cycle         = 0;
        test_reset();
        test_fairness();
        test_backpressure();
        test_lock();
        test_mask();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
